// File: rtl/weight_loader.sv
// Serial-to-column weight loader: gathers ROWS words per column and writes
// COLS assembled columns to the weight RAM, one strobe per column.
module weight_loader #(
    parameter int unsigned ROWS          = 16,
    parameter int unsigned COLS          = 8,
    parameter int unsigned BITWIDTH      = 18,
    parameter int unsigned ADDR_BITWIDTH = (COLS > 1) ? $clog2(COLS) : 1
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         startLoad,
    input  logic                         abort,
    input  logic [BITWIDTH-1:0]          inData,
    input  logic                         inValid,
    output logic                         inReady,
    output logic                         wrEnable,
    output logic [ADDR_BITWIDTH-1:0]     wrAddress,
    output logic [ROWS*BITWIDTH-1:0]     wrData,
    output logic                         busy,
    output logic                         loadDone
);

    localparam int unsigned ROW_W  = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int unsigned DATA_W = ROWS * BITWIDTH;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_e;

    state_e                   state_q, state_d;
    logic [ROW_W-1:0]         row_cnt_q, row_cnt_d;
    logic [ADDR_BITWIDTH-1:0] col_cnt_q, col_cnt_d;
    logic [DATA_W-1:0]        col_buf_q, col_buf_d;
    logic                     in_ready_q, in_ready_d;
    logic                     wr_enable_q, wr_enable_d;
    logic [ADDR_BITWIDTH-1:0] wr_address_q, wr_address_d;
    logic [DATA_W-1:0]        wr_data_q, wr_data_d;
    logic                     busy_q, busy_d;
    logic                     load_done_q, load_done_d;
    logic                     accept_c;

    // inReady is only ever high in FILL, so this also implies state FILL
    assign accept_c = in_ready_q & inValid;

    // Next-state, counters and next registered outputs
    always_comb begin
        state_d      = state_q;
        row_cnt_d    = row_cnt_q;
        col_cnt_d    = col_cnt_q;
        col_buf_d    = col_buf_q;
        wr_address_d = wr_address_q;
        wr_data_d    = wr_data_q;

        unique case (state_q)
            IDLE: begin
                if (startLoad) begin
                    state_d   = FILL;
                    row_cnt_d = '0;
                    col_cnt_d = '0;
                end
            end
            FILL: begin
                if (abort) begin
                    state_d   = IDLE;
                    row_cnt_d = '0;
                    col_cnt_d = '0;
                end else if (accept_c) begin
                    col_buf_d[row_cnt_q*BITWIDTH +: BITWIDTH] = inData;
                    if (row_cnt_q == ROW_W'(ROWS - 1)) begin
                        row_cnt_d    = '0;
                        state_d      = WRITE;
                        wr_address_d = col_cnt_q;
                        wr_data_d    = col_buf_d;
                    end else begin
                        row_cnt_d = row_cnt_q + ROW_W'(1);
                    end
                end
            end
            WRITE: begin
                if (abort) begin
                    state_d   = IDLE;
                    row_cnt_d = '0;
                    col_cnt_d = '0;
                end else if (col_cnt_q == ADDR_BITWIDTH'(COLS - 1)) begin
                    col_cnt_d = '0;
                    state_d   = DONE;
                end else begin
                    col_cnt_d = col_cnt_q + ADDR_BITWIDTH'(1);
                    state_d   = FILL;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        in_ready_d  = (state_d == FILL);
        wr_enable_d = (state_d == WRITE);
        busy_d      = (state_d != IDLE);
        load_done_d = (state_d == DONE);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            row_cnt_q    <= '0;
            col_cnt_q    <= '0;
            col_buf_q    <= '0;
            in_ready_q   <= 1'b0;
            wr_enable_q  <= 1'b0;
            wr_address_q <= '0;
            wr_data_q    <= '0;
            busy_q       <= 1'b0;
            load_done_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            row_cnt_q    <= row_cnt_d;
            col_cnt_q    <= col_cnt_d;
            col_buf_q    <= col_buf_d;
            in_ready_q   <= in_ready_d;
            wr_enable_q  <= wr_enable_d;
            wr_address_q <= wr_address_d;
            wr_data_q    <= wr_data_d;
            busy_q       <= busy_d;
            load_done_q  <= load_done_d;
        end
    end

    assign inReady   = in_ready_q;
    assign wrEnable  = wr_enable_q;
    assign wrAddress = wr_address_q;
    assign wrData    = wr_data_q;
    assign busy      = busy_q;
    assign loadDone  = load_done_q;

endmodule

// File: tb/tb_weight_loader.sv
// Testbench for weight_loader: word-count reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_weight_loader;

    localparam int ROWS = 16;
    localparam int COLS = 8;
    localparam int BW   = 18;
    localparam int AW   = 3;
    localparam int DW   = ROWS * BW;

    logic          clock = 1'b0;
    logic          reset;
    logic          startLoad = 1'b0;
    logic          abort = 1'b0;
    logic [BW-1:0] inData = '0;
    logic          inValid = 1'b0;
    logic          inReady;
    logic          wrEnable;
    logic [AW-1:0] wrAddress;
    logic [DW-1:0] wrData;
    logic          busy;
    logic          loadDone;

    int total = 0;
    int bad   = 0;

    weight_loader #(
        .ROWS(ROWS), .COLS(COLS), .BITWIDTH(BW), .ADDR_BITWIDTH(AW)
    ) dut (
        .clock(clock), .reset(reset), .startLoad(startLoad), .abort(abort),
        .inData(inData), .inValid(inValid), .inReady(inReady),
        .wrEnable(wrEnable), .wrAddress(wrAddress), .wrData(wrData),
        .busy(busy), .loadDone(loadDone)
    );

    always #5 clock = ~clock;

    task automatic check(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: a load is a count of accepted words; every ROWS words
    // yields one write cycle, and the final write is followed by one done cycle.
    bit            m_active = 0;
    bit            m_write  = 0;
    bit            m_done   = 0;
    int            m_cnt    = 0;
    logic [BW-1:0] m_col [ROWS];
    logic [AW-1:0] m_waddr = '0;
    logic [DW-1:0] m_wdata = '0;

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            m_active = 0; m_write = 0; m_done = 0; m_cnt = 0;
            m_waddr = '0; m_wdata = '0;
        end else if (!m_active) begin
            if (startLoad) begin
                m_active = 1; m_cnt = 0;
            end
        end else if (m_done) begin
            m_active = 0; m_done = 0;
        end else if (m_write) begin
            m_write = 0;
            if (abort) m_active = 0;
            else if (m_cnt == ROWS * COLS) m_done = 1;
        end else if (abort) begin
            m_active = 0;
        end else if (inValid) begin
            m_col[m_cnt % ROWS] = inData;
            m_cnt++;
            if (m_cnt % ROWS == 0) begin
                m_write = 1;
                m_waddr = AW'(m_cnt / ROWS - 1);
                for (int r = 0; r < ROWS; r++) m_wdata[r*BW +: BW] = m_col[r];
            end
        end
    end

    // Per-cycle comparison and event logging
    int            cyc = 0;
    int            wr_count = 0;
    int            done_count = 0;
    int            acc_first = -1;
    int            done_cyc = -1;
    logic [AW-1:0] addr_log [$];
    logic [DW-1:0] data_log [$];

    always @(negedge clock) begin
        cyc++;
        check("inReady",   DW'(inReady),   DW'(m_active && !m_write && !m_done));
        check("wrEnable",  DW'(wrEnable),  DW'(m_write));
        check("wrAddress", DW'(wrAddress), DW'(m_waddr));
        check("wrData",    wrData,         m_wdata);
        check("busy",      DW'(busy),      DW'(m_active));
        check("loadDone",  DW'(loadDone),  DW'(m_done));
        if (inValid && inReady && acc_first < 0) acc_first = cyc;
        if (wrEnable) begin
            wr_count++;
            addr_log.push_back(wrAddress);
            data_log.push_back(wrData);
        end
        if (loadDone) begin
            done_count++;
            done_cyc = cyc;
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic do_start();
        startLoad = 1'b1;
        @(posedge clock); #1;
        startLoad = 1'b0;
    endtask

    task automatic send_words(input int n, input int base, input bit gap, input int start_at);
        int k = 0;
        int budget = 0;
        bit tog = 1'b1;
        bit acc;
        bit pulsed = 1'b0;
        while (k < n && budget < 4000) begin
            inValid = gap ? tog : 1'b1;
            tog     = ~tog;
            inData  = BW'(base + k);
            if (start_at >= 0 && k == start_at && !pulsed) begin
                startLoad = 1'b1;
                pulsed    = 1'b1;
            end
            @(negedge clock);
            acc = inValid && inReady;
            @(posedge clock); #1;
            startLoad = 1'b0;
            if (acc) k++;
            budget++;
        end
        inValid = 1'b0;
        check("words_sent", DW'(k), DW'(n));
    endtask

    task automatic check_col(input string nm, input int idx, input int c, input int base);
        logic [DW-1:0] e;
        for (int r = 0; r < ROWS; r++) e[r*BW +: BW] = BW'(base + ROWS * c + r);
        check({nm, "_addr"}, DW'(addr_log[idx]), DW'(c));
        check({nm, "_data"}, data_log[idx], e);
    endtask

    initial begin
        int w0;
        int d0;
        reset = 1'b1;
        #1 reset = 1'b0;
        #2;
        check("rst_inReady",  DW'(inReady),   '0);
        check("rst_wrEnable", DW'(wrEnable),  '0);
        check("rst_wrAddr",   DW'(wrAddress), '0);
        check("rst_wrData",   wrData,         '0);
        check("rst_busy",     DW'(busy),      '0);
        check("rst_loadDone", DW'(loadDone),  '0);
        #9 reset = 1'b1;
        @(posedge clock); #1;

        // Full-rate load of words 0..127
        w0 = wr_count; d0 = done_count; acc_first = -1;
        do_start();
        send_words(128, 0, 1'b0, -1);
        wait_cycles(3);
        check("full_writes", DW'(wr_count - w0), DW'(8));
        check("full_done",   DW'(done_count - d0), DW'(1));
        check("full_latency", DW'(done_cyc - acc_first + 1), DW'(137));
        for (int c = 0; c < COLS; c++) check_col("full_col", w0 + c, c, 0);

        // Same stream with inValid on alternate cycles
        w0 = wr_count; d0 = done_count;
        do_start();
        send_words(128, 0, 1'b1, -1);
        wait_cycles(3);
        check("gap_writes", DW'(wr_count - w0), DW'(8));
        check("gap_done",   DW'(done_count - d0), DW'(1));
        for (int c = 0; c < COLS; c++) check_col("gap_col", w0 + c, c, 0);

        // Abort after 40 accepted words, then a clean reload
        w0 = wr_count; d0 = done_count;
        do_start();
        send_words(40, 500, 1'b0, -1);
        abort = 1'b1;
        @(posedge clock); #1;
        abort = 1'b0;
        check("abort_busy",    DW'(busy),    '0);
        check("abort_inReady", DW'(inReady), '0);
        wait_cycles(4);
        check("abort_writes", DW'(wr_count - w0), DW'(2));
        check("abort_done",   DW'(done_count - d0), '0);
        check_col("abort_col", w0, 0, 500);
        check_col("abort_col", w0 + 1, 1, 500);
        w0 = wr_count; d0 = done_count;
        do_start();
        send_words(128, 1000, 1'b0, -1);
        wait_cycles(3);
        check("reload_writes", DW'(wr_count - w0), DW'(8));
        check("reload_done",   DW'(done_count - d0), DW'(1));
        check_col("reload_col", w0, 0, 1000);
        check_col("reload_col", w0 + 7, 7, 1000);

        // Asynchronous reset in the middle of column 3
        w0 = wr_count; d0 = done_count;
        do_start();
        send_words(53, 2000, 1'b0, -1);
        #2 reset = 1'b0;
        #1;
        check("midrst_inReady",  DW'(inReady),   '0);
        check("midrst_wrEnable", DW'(wrEnable),  '0);
        check("midrst_wrAddr",   DW'(wrAddress), '0);
        check("midrst_wrData",   wrData,         '0);
        check("midrst_busy",     DW'(busy),      '0);
        check("midrst_loadDone", DW'(loadDone),  '0);
        @(posedge clock); #1;
        reset = 1'b1;
        inValid = 1'b1; inData = BW'(7);
        wait_cycles(20);
        inValid = 1'b0;
        check("midrst_writes", DW'(wr_count - w0), DW'(3));
        check("midrst_busy_after", DW'(busy), '0);
        check("midrst_done", DW'(done_count - d0), '0);

        // startLoad during FILL and DONE, abort during DONE: no restart
        w0 = wr_count; d0 = done_count;
        do_start();
        send_words(128, 3000, 1'b0, 20);
        @(posedge clock); #1;
        check("done_cycle", DW'(loadDone), DW'(1));
        startLoad = 1'b1; abort = 1'b1;
        @(posedge clock); #1;
        startLoad = 1'b0; abort = 1'b0;
        check("after_done_busy", DW'(busy), '0);
        wait_cycles(3);
        check("restart_writes", DW'(wr_count - w0), DW'(8));
        check("restart_done",   DW'(done_count - d0), DW'(1));
        check_col("restart_col", w0 + 3, 3, 3000);

        // inValid in IDLE without a start
        w0 = wr_count;
        inValid = 1'b1; inData = BW'(99);
        wait_cycles(10);
        check("idle_inReady", DW'(inReady), '0);
        check("idle_busy",    DW'(busy),    '0);
        inValid = 1'b0;
        wait_cycles(2);
        check("idle_writes", DW'(wr_count - w0), '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1);
    end

endmodule
